// File: rtl/fdiv_issue_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stalling pipelined divider.
// Optional FDIV_WB_BYPASS_EN: an empty FIFO lets a fresh result drive writeback directly.
module fdiv_issue_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_en,
  input  logic [31:0]      div_c,
  input  logic             div_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             busy,
  output logic             proto_err
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SumW  = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned MaskW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] tv_q, tv_d;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  logic [TAG_W-1:0]   tag_mem_q [DEPTH];
  logic [31:0]        data_mem_q [DEPTH];
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SumW-1:0]    cnt_q, cnt_d, inflight;
  logic [MaskW-1:0]   mask_q, mask_d;
  logic               proto_err_q, proto_err_d;
  logic               fire, rdy_m, cap, push, pop, fifo_nempty;
`ifdef FDIV_WB_BYPASS_EN
  logic               byp;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SumW'(tv_q[i]);
    end
    req_ready   = !rst && ((inflight + cnt_q) < SumW'(DEPTH));
    fire        = req_valid && req_ready;
    div_en      = fire;
    div_a       = req_a;
    div_b       = req_b;
    // Stale results from before a reset are ignored until the divider pipe has flushed.
    rdy_m       = div_ready && (mask_q == '0);
    cap         = !rst && rdy_m && tv_q[LATENCY-1];
    fifo_nempty = cnt_q != '0;
    pop         = !rst && fifo_nempty && wb_ready;
`ifdef FDIV_WB_BYPASS_EN
    byp      = cap && !fifo_nempty;
    push     = cap && !(byp && wb_ready);
    wb_valid = !rst && (fifo_nempty || byp);
    wb_tag   = '0;
    wb_data  = '0;
    if (wb_valid) begin
      wb_tag  = fifo_nempty ? tag_mem_q[rptr_q] : tag_q[LATENCY-1];
      wb_data = fifo_nempty ? data_mem_q[rptr_q] : div_c;
    end
`else
    push     = cap;
    wb_valid = !rst && fifo_nempty;
    wb_tag   = wb_valid ? tag_mem_q[rptr_q] : '0;
    wb_data  = wb_valid ? data_mem_q[rptr_q] : '0;
`endif
    busy      = !rst && ((inflight != '0) || fifo_nempty);
    proto_err = proto_err_q;

    tv_d[0]  = fire;
    tag_d[0] = fire ? req_tag : tag_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      tv_d[i]  = tv_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + SumW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - SumW'(1);
    end
    proto_err_d = proto_err_q || (rdy_m != tv_q[LATENCY-1]);
    mask_d      = (mask_q != '0) ? mask_q - MaskW'(1) : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q        <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
      mask_q      <= MaskW'(LATENCY);
    end else begin
      tv_q        <= tv_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      mask_q      <= mask_d;
    end
  end

  // Payload storage needs no reset; validity lives in tv_q and cnt_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      tag_q[i] <= tag_d[i];
    end
    if (push) begin
      tag_mem_q[wptr_q]  <= tag_q[LATENCY-1];
      data_mem_q[wptr_q] <= div_c;
    end
  end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Bench for fdiv_issue_ctrl: divider model, scoreboard monitor, vector table, corner sequences.
module tb_fdiv_issue_ctrl;

  localparam int Lat   = 4;
  localparam int Depth = 4;
`ifdef FDIV_WB_BYPASS_EN
  localparam int Byp = 1;
`else
  localparam int Byp = 0;
`endif
  localparam int Hit = Lat + 1 - Byp;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, div_en, div_ready, wb_valid, wb_ready, busy, proto_err;
  logic [31:0] req_a, req_b, div_a, div_b, div_c, wb_data;
  logic [4:0]  req_tag, wb_tag;
  logic        inj;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic chk_credit = 1'b0;
  logic hold_chk   = 1'b0;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        vld;
    logic [4:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        wbr;
    logic        rr;
    logic        wbv;
    logic [4:0]  wtag;
    logic        bsy;
  } vec_t;
  localparam int NV = 19;
  vec_t vt[NV];

  always #5 clk = ~clk;

  fdiv_issue_ctrl #(.LATENCY(Lat), .DEPTH(Depth), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_a(div_a), .div_b(div_b), .div_en(div_en), .div_c(div_c), .div_ready(div_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
    .busy(busy), .proto_err(proto_err)
  );

  function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // Divider model: fixed latency, no reset, no stall.
  logic [Lat-1:0] pv = '0;
  logic [31:0]    pd [Lat];
  always @(posedge clk) begin
    pv    <= {pv[Lat-2:0], div_en};
    pd[0] <= fdiv_model(div_a, div_b);
    for (int i = 1; i < Lat; i++) pd[i] <= pd[i-1];
  end
  assign div_ready = pv[Lat-1] | inj;
  assign div_c     = pd[Lat-1];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: credit model, hold stability, in-order delivery, overflow guard.
  initial begin
    logic        prev_hold;
    logic [4:0]  prev_tag;
    logic [31:0] prev_data;
    exp_t        e;
    prev_hold = 1'b0;
    prev_tag  = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_hold = 1'b0;
      end else begin
        if (chk_credit) chk1("credit", req_ready, sb.size() < Depth);
        if (hold_chk && prev_hold) begin
          chk32("hold_tag", {27'd0, wb_tag}, {27'd0, prev_tag});
          chk32("hold_data", wb_data, prev_data);
        end
        prev_hold = wb_valid && !wb_ready;
        prev_tag  = wb_tag;
        prev_data = wb_data;
        if (dut.push) chk1("no_overflow", int'(dut.cnt_q) < Depth, 1'b1);
        if (wb_valid && wb_ready) begin
          pops++;
          if (sb.size() == 0) begin
            chk1("spurious_result", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            chk32("wb_tag_order", {27'd0, wb_tag}, {27'd0, e.tag});
            chk32("wb_data", wb_data, e.data);
          end
        end
        if (req_valid && req_ready) begin
          e.tag  = req_tag;
          e.data = fdiv_model(req_a, req_b);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    int p0;
    logic acc;

    for (int i = 0; i < 8; i++) begin
      vt[i].vld  = (i == 0);
      vt[i].tag  = 5'd3;
      vt[i].a    = 32'h40C00000;
      vt[i].b    = 32'h40000000;
      vt[i].wbr  = 1'b1;
      vt[i].rr   = 1'b1;
      vt[i].wbv  = (i == Hit);
      vt[i].wtag = 5'd3;
      vt[i].bsy  = (i >= 1 && i <= Hit);
    end
    for (int k = 0; k < NV - 8; k++) begin
      vt[8+k].vld  = (k < 4);
      vt[8+k].tag  = 5'(k + 1);
      vt[8+k].a    = 32'h3F800000 + 32'(k);
      vt[8+k].b    = 32'h40000000 + 32'(k * 3);
      vt[8+k].wbr  = 1'b0;
      vt[8+k].rr   = (k < 4);
      vt[8+k].wbv  = (k >= Hit);
      vt[8+k].wtag = 5'd1;
      vt[8+k].bsy  = (k >= 1);
    end

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    wb_ready = 1'b0; inj = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    repeat (2) next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_proto_err", proto_err, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    next_cyc();

    for (int i = 0; i < NV; i++) begin
      req_valid = vt[i].vld; req_tag = vt[i].tag; req_a = vt[i].a; req_b = vt[i].b;
      wb_ready  = vt[i].wbr;
      @(negedge clk);
      chk1($sformatf("vec%0d req_ready", i), req_ready, vt[i].rr);
      chk1($sformatf("vec%0d wb_valid", i), wb_valid, vt[i].wbv);
      if (vt[i].wbv) chk32($sformatf("vec%0d wb_tag", i), {27'd0, wb_tag}, {27'd0, vt[i].wtag});
      chk1($sformatf("vec%0d busy", i), busy, vt[i].bsy);
      next_cyc();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk32("b2b_cnt_full", 32'(dut.cnt_q), 32'd4);
    next_cyc();
    wb_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      chk1($sformatf("drain%0d wb_valid", m), wb_valid, m < 4);
      if (m < 4) chk32($sformatf("drain%0d wb_tag", m), {27'd0, wb_tag}, 32'(m + 1));
      chk1($sformatf("drain%0d req_ready", m), req_ready, m != 0);
      next_cyc();
    end

    // Continuous stream with writeback always ready.
    chk_credit = 1'b1;
    n = 0; cyc = 0;
    req_valid = 1'b1; req_tag = '0; req_a = $urandom; req_b = $urandom;
    while (n < 100 && cyc < 1000) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) n++;
      next_cyc();
      if (acc) begin req_tag = 5'(n); req_a = $urandom; req_b = $urandom; end
      cyc++;
    end
    req_valid = 1'b0;
    chk32("stream_accepted", 32'(n), 32'd100);
    repeat (10) next_cyc();
    chk32("stream_drained", 32'(sb.size()), 32'd0);

    // Backpressure with wb_ready toggling 1,0,1,0.
    hold_chk = 1'b1;
    n = 0;
    for (int c = 0; c < 120; c++) begin
      wb_ready  = (c % 2 == 0);
      req_valid = (n < 20);
      @(negedge clk);
      acc = req_valid && req_ready;
      if (acc) n++;
      next_cyc();
      if (acc) begin req_tag = 5'(n + 10); req_a = $urandom; req_b = $urandom; end
    end
    req_valid = 1'b0; wb_ready = 1'b1;
    repeat (10) next_cyc();
    hold_chk = 1'b0;
    chk32("bp_accepted", 32'(n), 32'd20);
    chk32("bp_drained", 32'(sb.size()), 32'd0);

    // Protocol error: result strobe with an empty tag pipe.
    @(negedge clk);
    chk1("perr_before", proto_err, 1'b0);
    next_cyc();
    inj = 1'b1;
    @(negedge clk);
    chk1("perr_no_wb", wb_valid, 1'b0);
    next_cyc();
    inj = 1'b0;
    @(negedge clk);
    chk1("perr_set", proto_err, 1'b1);
    chk32("perr_cnt", 32'(dut.cnt_q), 32'd0);
    chk1("perr_busy", busy, 1'b0);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      @(negedge clk);
      chk1($sformatf("perr_sticky%0d", c), proto_err, 1'b1);
    end
    next_cyc();

    // Reset two cycles after an issue; the stale result must be ignored.
    chk_credit = 1'b0;
    req_valid = 1'b1; req_tag = 5'd7; req_a = 32'h40C00000; req_b = 32'h40000000;
    @(negedge clk);
    chk1("mid_fire", req_ready, 1'b1);
    next_cyc();
    req_valid = 1'b0;
    next_cyc();
    rst = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    chk1("mid_rst req_ready", req_ready, 1'b0);
    chk1("mid_rst div_en", div_en, 1'b0);
    chk1("mid_rst wb_valid", wb_valid, 1'b0);
    chk32("mid_rst wb_tag", {27'd0, wb_tag}, 32'd0);
    chk32("mid_rst wb_data", wb_data, 32'd0);
    chk1("mid_rst busy", busy, 1'b0);
    next_cyc();
    rst = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk1($sformatf("post_rst%0d wb_valid", c), wb_valid, 1'b0);
      chk1($sformatf("post_rst%0d proto_err", c), proto_err, 1'b0);
      chk1($sformatf("post_rst%0d busy", c), busy, 1'b0);
      next_cyc();
    end

    // Normal operation resumes after reset.
    p0 = pops;
    req_valid = 1'b1; req_tag = 5'd9; req_a = 32'h40C00000; req_b = 32'h40000000;
    next_cyc();
    req_valid = 1'b0;
    repeat (8) next_cyc();
    chk32("recover_delivered", 32'(pops - p0), 32'd1);
    chk32("recover_drained", 32'(sb.size()), 32'd0);
    chk1("recover_proto_err", proto_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
